tlp_tx_arbiter: RTL and testbench
=================================

Name: tlp_tx_arbiter

Overview:
- Shares the PCIe x1 core's VC0 transmit TLP interface between two requesters, e.g. a DMA engine and an MSI/config responder.
- Sits between the requesters and the core's tx_*_vc0 ports and owns tx_req_vc0.
- Grants one whole TLP at a time, round-robin, with per-requester packet counters for status and debug.

Parameters:
- DATA_W, 16, TLP data width; matches the core's tx_data_vc0.
- CNT_W, 16, width of each per-requester packet counter.

Ports:
- clk  input  1  system clock (core's 125 MHz user clock).
- rstn  input  1  synchronous reset, active low.
- req0, req1  input  1  requester wants to send one TLP.
- rdy0, rdy1  output  1  core-ready forwarded to the granted requester.
- data0, data1  input  DATA_W  requester TLP data.
- st0, st1  input  1  requester start-of-TLP.
- end0, end1  input  1  requester end-of-TLP.
- nlfy0, nlfy1  input  1  requester nullify, valid with end.
- tx_req_vc0  output  1  to core: transmit request.
- tx_rdy_vc0  input  1  from core: ready to accept data.
- tx_data_vc0  output  DATA_W  to core.
- tx_st_vc0  output  1  to core.
- tx_end_vc0  output  1  to core.
- tx_nlfy_vc0  output  1  to core.
- busy  output  1  state is not IDLE.
- gnt  output  2  one-hot current grant; 00 in IDLE.
- pkt_cnt0, pkt_cnt1  output  CNT_W  completed TLPs per requester.

Behaviour:
- Reset: synchronous; sampled low at a clk rising edge.
  - state=IDLE, sel=0, last=1 (requester 0 wins the first tie), pkt_cnt0/1=0.
  - All outputs are 0 from the cycle after the reset edge.
  - Reset mid-packet abandons the TLP with no end is sent; the requester must restart.
- States: IDLE, GRANT, XFER.
- IDLE:
  - tx_req_vc0=0, all rdy=0.
  - If exactly one req is high, select it.
  - If both are high, select the requester != last.
  - Register sel and go to GRANT; tx_req_vc0 rises on the next cycle (1-cycle latency from req).
- GRANT:
  - tx_req_vc0=1.
  - rdy[sel]=tx_rdy_vc0 (combinational); non-selected rdy=0.
  - If req[sel] drops before any st is accepted, go to IDLE; last is unchanged, no count.
  - st[sel]&tx_rdy_vc0 accepts the first beat.
    - With end[sel] in the same cycle (single beat): go to IDLE and perform completion.
    - Otherwise go to XFER.
  - st[sel] while tx_rdy_vc0=0 is ignored; the requester holds st.
- XFER:
  - tx_req_vc0=0; rdy[sel]=tx_rdy_vc0.
  - req[sel] is ignored; the packet runs to end.
  - end[sel]&tx_rdy_vc0: go to IDLE and perform completion.
  - A second st[sel] is passed through unchanged (requester protocol error, not checked).
- Completion: last<=sel; pkt_cnt[sel] increments, wrapping from 2^CNT_W-1 to 0.
- Datapath:
  - In GRANT/XFER: tx_data/tx_st/tx_end/tx_nlfy = requester[sel] signals, combinational mux.
  - In IDLE: all forced to 0.
  - tx_nlfy_vc0 is forwarded only when tx_end_vc0 is 1, else 0.
- Turnaround: end accepted at cycle m → IDLE at m+1 → next tx_req_vc0 at m+2.
- gnt = one-hot(sel) in GRANT/XFER, 00 in IDLE. busy = (state!=IDLE).
- A requester never sees rdy while not granted, even if tx_rdy_vc0=1.

Test Plan:
- Single requester: req0 held, tx_rdy high 2 cycles after tx_req; 4-beat TLP data 0x1111..0x4444 → tx_req_vc0 at cycle+1, exact beats on tx_data_vc0, st on beat 1, end on beat 4, pkt_cnt0=1, gnt=00 after end.
- Contention: req0 and req1 asserted together from reset, 3 back-to-back 2-beat TLPs each → grant order 0,1,0,1,0,1; pkt_cnt0=pkt_cnt1=3; rdy1 never high while gnt=01.
- Single-beat TLP (st&end same cycle) with nlfy1=1 → tx_nlfy_vc0=1 for that beat only, IDLE the next cycle, pkt_cnt1 increments.
- Backpressure: tx_rdy_vc0 toggles 1,0,0,1 mid-XFER → data beat held and accepted only on rdy-high cycles, no duplicate or dropped beat.
- Abort and reset: req1 drops in GRANT before st → IDLE, pkt_cnt1 unchanged, last unchanged. Separately, rstn low mid-XFER → all outputs 0 next cycle, counters 0, req0 wins the next tie.
- Wrap: CNT_W=2, 5 TLPs on requester 0 → pkt_cnt0 sequence 1,2,3,0,1.

Source files
------------

// File: rtl/tlp_tx_arbiter.sv
// Round-robin arbiter that shares the PCIe core's VC0 transmit TLP port between two requesters.
// Grants one whole TLP at a time and keeps a wrapping count of completed TLPs per requester.
module tlp_tx_arbiter #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req0,
  input  logic              req1,
  output logic              rdy0,
  output logic              rdy1,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  input  logic              st0,
  input  logic              st1,
  input  logic              end0,
  input  logic              end1,
  input  logic              nlfy0,
  input  logic              nlfy1,
  output logic              tx_req_vc0,
  input  logic              tx_rdy_vc0,
  output logic [DATA_W-1:0] tx_data_vc0,
  output logic              tx_st_vc0,
  output logic              tx_end_vc0,
  output logic              tx_nlfy_vc0,
  output logic              busy,
  output logic [1:0]        gnt,
  output logic [CNT_W-1:0]  pkt_cnt0,
  output logic [CNT_W-1:0]  pkt_cnt1
);

  typedef enum logic [1:0] {IDLE, GRANT, XFER} state_t;

  state_t            state_reg;
  logic              sel_reg;
  logic              last_reg;
  logic              tx_req_reg;
  logic              busy_reg;
  logic [1:0]        gnt_reg;

  logic [1:0]        req_v;
  logic [1:0]        st_v;
  logic [1:0]        end_v;
  logic [1:0]        nlfy_v;
  logic [1:0]        rdy_v;
  logic [DATA_W-1:0] data_v [2];
  logic [CNT_W-1:0]  cnt_reg [2];

  assign req_v     = {req1, req0};
  assign st_v      = {st1, st0};
  assign end_v     = {end1, end0};
  assign nlfy_v    = {nlfy1, nlfy0};
  assign data_v[0] = data0;
  assign data_v[1] = data1;

  logic              active;
  logic              cur_req;
  logic              cur_st;
  logic              cur_end;
  logic              cur_nlfy;
  logic [DATA_W-1:0] cur_data;
  logic              pick;
  logic              accept_first;
  logic              complete;

  assign active   = (state_reg != IDLE);
  assign cur_req  = req_v[sel_reg];
  assign cur_st   = st_v[sel_reg];
  assign cur_end  = end_v[sel_reg];
  assign cur_nlfy = nlfy_v[sel_reg];
  assign cur_data = data_v[sel_reg];

  // On a tie the requester that did not complete last wins; otherwise the lone requester.
  assign pick = (req_v == 2'b11) ? ~last_reg : req_v[1];

  assign accept_first = (state_reg == GRANT) && cur_st && tx_rdy_vc0;
  assign complete     = (accept_first && cur_end) ||
                        ((state_reg == XFER) && cur_end && tx_rdy_vc0);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg  <= IDLE;
      sel_reg    <= 1'b0;
      last_reg   <= 1'b1;
      tx_req_reg <= 1'b0;
      busy_reg   <= 1'b0;
      gnt_reg    <= 2'b00;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_v != 2'b00) begin
            state_reg  <= GRANT;
            sel_reg    <= pick;
            tx_req_reg <= 1'b1;
            busy_reg   <= 1'b1;
            gnt_reg    <= pick ? 2'b10 : 2'b01;
          end
        end
        GRANT: begin
          if (accept_first) begin
            tx_req_reg <= 1'b0;
            if (cur_end) begin
              state_reg <= IDLE;
              last_reg  <= sel_reg;
              busy_reg  <= 1'b0;
              gnt_reg   <= 2'b00;
            end else begin
              state_reg <= XFER;
            end
          end else if (!cur_req) begin
            // Withdrawn before the first beat: no packet happened, fairness untouched.
            state_reg  <= IDLE;
            tx_req_reg <= 1'b0;
            busy_reg   <= 1'b0;
            gnt_reg    <= 2'b00;
          end
        end
        XFER: begin
          if (cur_end && tx_rdy_vc0) begin
            state_reg <= IDLE;
            last_reg  <= sel_reg;
            busy_reg  <= 1'b0;
            gnt_reg   <= 2'b00;
          end
        end
        default: begin
          state_reg  <= IDLE;
          tx_req_reg <= 1'b0;
          busy_reg   <= 1'b0;
          gnt_reg    <= 2'b00;
        end
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      localparam logic GSEL = 1'(gi);

      assign rdy_v[gi] = active && (sel_reg == GSEL) && tx_rdy_vc0;

      always_ff @(posedge clk) begin
        if (!rstn) begin
          cnt_reg[gi] <= '0;
        end else if (complete && (sel_reg == GSEL)) begin
          cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
        end
      end
    end
  endgenerate

  assign rdy0     = rdy_v[0];
  assign rdy1     = rdy_v[1];
  assign pkt_cnt0 = cnt_reg[0];
  assign pkt_cnt1 = cnt_reg[1];

  assign tx_req_vc0  = tx_req_reg;
  assign busy        = busy_reg;
  assign gnt         = gnt_reg;
  assign tx_data_vc0 = active ? cur_data : '0;
  assign tx_st_vc0   = active & cur_st;
  assign tx_end_vc0  = active & cur_end;
  assign tx_nlfy_vc0 = active & cur_end & cur_nlfy;

endmodule

// File: tb/tb_tlp_tx_arbiter.sv
// Directed bench for tlp_tx_arbiter; a second instance with 2-bit counters shares the stimulus
// so counter wrap can be observed.
module tb_tlp_tx_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req0, req1, st0, st1, end0, end1, nlfy0, nlfy1, tx_rdy_vc0;
  logic [15:0] data0, data1;

  logic        rdy0, rdy1, tx_req_vc0, tx_st_vc0, tx_end_vc0, tx_nlfy_vc0, busy;
  logic [15:0] tx_data_vc0, pkt_cnt0, pkt_cnt1;
  logic [1:0]  gnt;

  logic        w_rdy0, w_rdy1, w_tx_req, w_tx_st, w_tx_end, w_tx_nlfy, w_busy;
  logic [15:0] w_tx_data;
  logic [1:0]  w_gnt, w_pkt_cnt0, w_pkt_cnt1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  tlp_tx_arbiter #(.DATA_W(16), .CNT_W(16)) dut (
    .clk(clk), .rstn(rstn), .req0(req0), .req1(req1), .rdy0(rdy0), .rdy1(rdy1),
    .data0(data0), .data1(data1), .st0(st0), .st1(st1), .end0(end0), .end1(end1),
    .nlfy0(nlfy0), .nlfy1(nlfy1), .tx_req_vc0(tx_req_vc0), .tx_rdy_vc0(tx_rdy_vc0),
    .tx_data_vc0(tx_data_vc0), .tx_st_vc0(tx_st_vc0), .tx_end_vc0(tx_end_vc0),
    .tx_nlfy_vc0(tx_nlfy_vc0), .busy(busy), .gnt(gnt), .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
  );

  tlp_tx_arbiter #(.DATA_W(16), .CNT_W(2)) u_wrap (
    .clk(clk), .rstn(rstn), .req0(req0), .req1(req1), .rdy0(w_rdy0), .rdy1(w_rdy1),
    .data0(data0), .data1(data1), .st0(st0), .st1(st1), .end0(end0), .end1(end1),
    .nlfy0(nlfy0), .nlfy1(nlfy1), .tx_req_vc0(w_tx_req), .tx_rdy_vc0(tx_rdy_vc0),
    .tx_data_vc0(w_tx_data), .tx_st_vc0(w_tx_st), .tx_end_vc0(w_tx_end),
    .tx_nlfy_vc0(w_tx_nlfy), .busy(w_busy), .gnt(w_gnt), .pkt_cnt0(w_pkt_cnt0), .pkt_cnt1(w_pkt_cnt1)
  );

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0 = 0; req1 = 0; st0 = 0; st1 = 0; end0 = 0; end1 = 0;
    nlfy0 = 0; nlfy1 = 0; data0 = '0; data1 = '0; tx_rdy_vc0 = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rstn = 0;
    nxt();
    nxt();
    rstn = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    tx_rdy_vc0 = 1;
    req0 = 1;
    rstn = 0;
    nxt();
    #1;
    n_tests++;
    if ({tx_req_vc0, busy, gnt, rdy0, rdy1} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b required 000000", {tx_req_vc0, busy, gnt, rdy0, rdy1});
    end
    n_tests++;
    if ({pkt_cnt0, pkt_cnt1, tx_data_vc0} !== 48'h0) begin
      n_fail++; $display("FAIL reset_cnt_data: got %h required 0", {pkt_cnt0, pkt_cnt1, tx_data_vc0});
    end
    $display("[TB] reset: outputs idle");
    do_reset();
  endtask

  task automatic test_single();
    logic [15:0] beats [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    req0 = 1; st0 = 1; data0 = beats[0]; tx_rdy_vc0 = 0;
    #1;
    n_tests++;
    if (tx_req_vc0 !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL single_idle: tx_req %b busy %b required 0 0", tx_req_vc0, busy);
    end
    nxt();
    for (int k = 0; k < 2; k++) begin
      #1;
      n_tests++;
      if (tx_req_vc0 !== 1'b1 || gnt !== 2'b01 || rdy0 !== 1'b0) begin
        n_fail++; $display("FAIL single_grant%0d: req %b gnt %b rdy0 %b required 1 01 0", k, tx_req_vc0, gnt, rdy0);
      end
      nxt();
    end
    for (int b = 0; b < 4; b++) begin
      data0 = beats[b]; st0 = (b == 0); end0 = (b == 3); tx_rdy_vc0 = 1;
      #1;
      n_tests++;
      if (tx_data_vc0 !== beats[b] || tx_st_vc0 !== (b == 0) || tx_end_vc0 !== (b == 3) ||
          rdy0 !== 1'b1 || tx_req_vc0 !== (b == 0)) begin
        n_fail++; $display("FAIL single_beat%0d: data %h st %b end %b rdy0 %b req %b required %h %b %b 1 %b",
                           b, tx_data_vc0, tx_st_vc0, tx_end_vc0, rdy0, tx_req_vc0, beats[b], b == 0, b == 3, b == 0);
      end
      nxt();
    end
    idle_inputs();
    #1;
    n_tests++;
    if (gnt !== 2'b00 || busy !== 1'b0 || pkt_cnt0 !== 16'd1 || tx_req_vc0 !== 1'b0) begin
      n_fail++; $display("FAIL single_done: gnt %b busy %b cnt0 %0d required 00 0 1", gnt, busy, pkt_cnt0);
    end
    $display("[TB] single: 4-beat TLP on requester 0");
  endtask

  task automatic test_contention();
    logic       w;
    logic [1:0] exp_gnt;
    do_reset();
    tx_rdy_vc0 = 1;
    for (int i = 0; i < 6; i++) begin
      w = 1'(i % 2);
      exp_gnt = w ? 2'b10 : 2'b01;
      req0 = 1; req1 = 1; st0 = 1; st1 = 1; end0 = 0; end1 = 0;
      data0 = 16'hA000 + 16'(i); data1 = 16'hB000 + 16'(i);
      #1;
      n_tests++;
      if (busy !== 1'b0 || tx_req_vc0 !== 1'b0) begin
        n_fail++; $display("FAIL cont_idle%0d: busy %b req %b required 0 0", i, busy, tx_req_vc0);
      end
      nxt();
      #1;
      n_tests++;
      if (gnt !== exp_gnt || tx_req_vc0 !== 1'b1 || {rdy1, rdy0} !== exp_gnt ||
          tx_data_vc0 !== (w ? data1 : data0)) begin
        n_fail++; $display("FAIL cont_grant%0d: gnt %b rdy %b data %h required %b %b %h",
                           i, gnt, {rdy1, rdy0}, tx_data_vc0, exp_gnt, exp_gnt, w ? data1 : data0);
      end
      nxt();
      st0 = 0; st1 = 0; end0 = 1; end1 = 1;
      #1;
      n_tests++;
      if ({rdy1, rdy0} !== exp_gnt || tx_end_vc0 !== 1'b1 || gnt !== exp_gnt) begin
        n_fail++; $display("FAIL cont_end%0d: rdy %b end %b gnt %b required %b 1 %b",
                           i, {rdy1, rdy0}, tx_end_vc0, gnt, exp_gnt, exp_gnt);
      end
      $display("[TB] contention: TLP %0d granted to requester %0d", i, gnt[1]);
      nxt();
    end
    idle_inputs();
    #1;
    n_tests++;
    if (pkt_cnt0 !== 16'd3 || pkt_cnt1 !== 16'd3) begin
      n_fail++; $display("FAIL cont_counts: cnt0 %0d cnt1 %0d required 3 3", pkt_cnt0, pkt_cnt1);
    end
  endtask

  task automatic test_single_beat_nlfy();
    req1 = 1; st1 = 1; end1 = 1; nlfy1 = 1; data1 = 16'h5A5A; tx_rdy_vc0 = 1;
    nxt();
    #1;
    n_tests++;
    if ({tx_st_vc0, tx_end_vc0, tx_nlfy_vc0} !== 3'b111 || gnt !== 2'b10 || rdy1 !== 1'b1 ||
        tx_data_vc0 !== 16'h5A5A) begin
      n_fail++; $display("FAIL nlfy_beat: st/end/nlfy %b gnt %b rdy1 %b data %h required 111 10 1 5a5a",
                         {tx_st_vc0, tx_end_vc0, tx_nlfy_vc0}, gnt, rdy1, tx_data_vc0);
    end
    nxt();
    idle_inputs();
    #1;
    n_tests++;
    if (busy !== 1'b0 || tx_nlfy_vc0 !== 1'b0 || pkt_cnt1 !== 16'd4) begin
      n_fail++; $display("FAIL nlfy_done: busy %b nlfy %b cnt1 %0d required 0 0 4", busy, tx_nlfy_vc0, pkt_cnt1);
    end
    $display("[TB] single-beat nullified TLP on requester 1");
  endtask

  task automatic test_backpressure();
    logic [15:0] beats [4] = '{16'hC000, 16'hC001, 16'hC002, 16'hC003};
    logic        pat [5]   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    int          b;
    req0 = 1; st0 = 1; data0 = beats[0]; nlfy0 = 1; tx_rdy_vc0 = 1;
    nxt();
    nxt();
    st0 = 0;
    b = 1;
    for (int c = 0; c < 5; c++) begin
      data0 = beats[b]; end0 = (b == 3); tx_rdy_vc0 = pat[c];
      #1;
      n_tests++;
      if (tx_data_vc0 !== beats[b] || rdy0 !== pat[c] || tx_nlfy_vc0 !== (b == 3) || busy !== 1'b1) begin
        n_fail++; $display("FAIL bp_cycle%0d: data %h rdy0 %b nlfy %b busy %b required %h %b %b 1",
                           c, tx_data_vc0, rdy0, tx_nlfy_vc0, busy, beats[b], pat[c], b == 3);
      end
      if (pat[c]) b++;
      nxt();
    end
    idle_inputs();
    #1;
    n_tests++;
    if (busy !== 1'b0 || pkt_cnt0 !== 16'd4) begin
      n_fail++; $display("FAIL bp_done: busy %b cnt0 %0d required 0 4", busy, pkt_cnt0);
    end
    $display("[TB] backpressure: 4 beats accepted over 5 XFER cycles");
  endtask

  task automatic test_abort();
    req1 = 1;
    nxt();
    #1;
    n_tests++;
    if (gnt !== 2'b10) begin
      n_fail++; $display("FAIL abort_grant: gnt %b required 10", gnt);
    end
    req1 = 0;
    nxt();
    #1;
    n_tests++;
    if (busy !== 1'b0 || pkt_cnt1 !== 16'd4) begin
      n_fail++; $display("FAIL abort_idle: busy %b cnt1 %0d required 0 4", busy, pkt_cnt1);
    end
    req0 = 1; req1 = 1;
    nxt();
    #1;
    n_tests++;
    if (gnt !== 2'b10) begin
      n_fail++; $display("FAIL abort_last: gnt %b required 10", gnt);
    end
    idle_inputs();
    nxt();
    $display("[TB] abort: requester 1 withdrew in GRANT");
  endtask

  task automatic test_reset_mid();
    req0 = 1; st0 = 1; data0 = 16'h7777; tx_rdy_vc0 = 1;
    nxt();
    nxt();
    st0 = 0;
    #1;
    n_tests++;
    if (busy !== 1'b1 || tx_req_vc0 !== 1'b0 || gnt !== 2'b01) begin
      n_fail++; $display("FAIL rmid_xfer: busy %b req %b gnt %b required 1 0 01", busy, tx_req_vc0, gnt);
    end
    rstn = 0;
    nxt();
    #1;
    n_tests++;
    if ({tx_req_vc0, busy, gnt, rdy0, rdy1, tx_st_vc0, tx_end_vc0, tx_nlfy_vc0} !== 9'b0 ||
        tx_data_vc0 !== 16'h0 || pkt_cnt0 !== 16'h0 || pkt_cnt1 !== 16'h0) begin
      n_fail++; $display("FAIL rmid_outputs: ctrl %b data %h cnt0 %0d cnt1 %0d required all 0",
                         {tx_req_vc0, busy, gnt, rdy0, rdy1, tx_st_vc0, tx_end_vc0, tx_nlfy_vc0},
                         tx_data_vc0, pkt_cnt0, pkt_cnt1);
    end
    rstn = 1; req0 = 1; req1 = 1;
    nxt();
    #1;
    n_tests++;
    if (gnt !== 2'b01) begin
      n_fail++; $display("FAIL rmid_tie: gnt %b required 01", gnt);
    end
    idle_inputs();
    nxt();
    $display("[TB] reset mid-XFER: outputs cleared, requester 0 wins tie");
  endtask

  task automatic test_wrap();
    logic [1:0] exp_cnt;
    do_reset();
    req0 = 1; st0 = 1; end0 = 1; data0 = 16'hD00D; tx_rdy_vc0 = 1;
    for (int i = 0; i < 5; i++) begin
      nxt();
      nxt();
      exp_cnt = 2'((i + 1) % 4);
      #1;
      n_tests++;
      if (w_pkt_cnt0 !== exp_cnt || pkt_cnt0 !== 16'(i + 1)) begin
        n_fail++; $display("FAIL wrap%0d: w_cnt0 %0d cnt0 %0d required %0d %0d", i, w_pkt_cnt0, pkt_cnt0, exp_cnt, i + 1);
      end
      $display("[TB] wrap: TLP %0d, 2-bit count %0d", i, w_pkt_cnt0);
    end
    idle_inputs();
    nxt();
  endtask

  initial begin
    idle_inputs();
    rstn = 0;
    test_reset();
    test_single();
    test_contention();
    test_single_beat_nlfy();
    test_backpressure();
    test_abort();
    test_reset_mid();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
